// File: rtl/data_ram_arbiter_pkg.sv
// Shared sizing defaults and port indices for the data RAM arbiter and its users.
package data_ram_arbiter_pkg;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 64;
  localparam int N_PORTS = 2;
  localparam int P_MEM   = 0;
  localparam int P_DBG   = 1;
endpackage

// File: rtl/data_ram_arbiter_rr_arb2.sv
// Two-input round-robin grant; on a tie the port not granted last wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  logic last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (gnt_o[1])      last_d = 1'b1;
    else if (gnt_o[0]) last_d = 1'b0;
  end

  // Reset to port 1 so that port 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
endmodule

// File: rtl/data_ram_arbiter.sv
// Shares the single-port data RAM between the MEM stage (port 0) and the debug/loader port (port 1).
module data_ram_arbiter #(
  parameter int ADDR_W = data_ram_arbiter_pkg::ADDR_W,
  parameter int DATA_W = data_ram_arbiter_pkg::DATA_W,
  parameter int DEPTH  = data_ram_arbiter_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_din_o,
  output logic              ram_we_o,
  input  logic [DATA_W-1:0] ram_dout_i
);
  import data_ram_arbiter_pkg::*;

  localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH);

  logic [N_PORTS-1:0] req_v, we_v, elig, gnt, ack_v, err_v;
  logic [ADDR_W-1:0]  addr_v  [N_PORTS];
  logic [DATA_W-1:0]  wdata_v [N_PORTS];
  logic [DATA_W-1:0]  rdata_v [N_PORTS];
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_we;
  logic               in_range;

  assign req_v[P_MEM]   = m0_req_i;
  assign req_v[P_DBG]   = m1_req_i;
  assign we_v[P_MEM]    = m0_we_i;
  assign we_v[P_DBG]    = m1_we_i;
  assign addr_v[P_MEM]  = m0_addr_i;
  assign addr_v[P_DBG]  = m1_addr_i;
  assign wdata_v[P_MEM] = m0_wdata_i;
  assign wdata_v[P_DBG] = m1_wdata_i;

  // A port in its ack cycle is finishing the previous transaction, so it sits out.
  assign elig = req_v & ~ack_v;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (elig),
    .gnt_o (gnt)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (gnt[k]) begin
        sel_addr  = addr_v[k];
        sel_wdata = wdata_v[k];
        sel_we    = we_v[k];
      end
    end
  end

  // Low address bits are dropped, so misaligned accesses alias onto their word.
  assign in_range   = (sel_addr >> 2) < DEPTH_LIM;
  assign ram_addr_o = sel_addr;
  assign ram_din_o  = sel_wdata;
  assign ram_we_o   = sel_we & in_range & ~rst;

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
    logic              ack_q, ack_d, err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_comb begin
      ack_d   = gnt[gi];
      err_d   = gnt[gi] & ~in_range;
      rdata_d = rdata_q;
      if (gnt[gi]) rdata_d = (~sel_we & in_range) ? ram_dout_i : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ack_q   <= 1'b0;
        err_q   <= 1'b0;
        rdata_q <= '0;
      end else begin
        ack_q   <= ack_d;
        err_q   <= err_d;
        rdata_q <= rdata_d;
      end
    end

    assign ack_v[gi]   = ack_q;
    assign err_v[gi]   = err_q;
    assign rdata_v[gi] = rdata_q;
  end

  assign m0_ack_o   = ack_v[P_MEM];
  assign m0_err_o   = err_v[P_MEM];
  assign m0_rdata_o = rdata_v[P_MEM];
  assign m1_ack_o   = ack_v[P_DBG];
  assign m1_err_o   = err_v[P_DBG];
  assign m1_rdata_o = rdata_v[P_DBG];
endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed and randomized checks of data_ram_arbiter against a transaction-level model and a 64-word RAM.
module tb_data_ram_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        init_ram;
  logic [1:0]  req, we, ack, err;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [31:0] ram_addr, ram_din, ram_dout;
  logic        ram_we;

  logic [31:0] ram     [64];
  logic [31:0] ref_mem [64];
  int          last_port;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [1:0]  pending  = 2'b00;

  always #5 clk = ~clk;

  data_ram_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .m0_req_i   (req[0]),
    .m0_we_i    (we[0]),
    .m0_addr_i  (addr[0]),
    .m0_wdata_i (wdata[0]),
    .m0_ack_o   (ack[0]),
    .m0_err_o   (err[0]),
    .m0_rdata_o (rdata[0]),
    .m1_req_i   (req[1]),
    .m1_we_i    (we[1]),
    .m1_addr_i  (addr[1]),
    .m1_wdata_i (wdata[1]),
    .m1_ack_o   (ack[1]),
    .m1_err_o   (err[1]),
    .m1_rdata_o (rdata[1]),
    .ram_addr_o (ram_addr),
    .ram_din_o  (ram_din),
    .ram_we_o   (ram_we),
    .ram_dout_i (ram_dout)
  );

  // Bench-side RAM: synchronous write, combinational read, word i initialised to i.
  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < 64; i++) ram[i] <= i;
    end else if (ram_we) begin
      ram[ram_addr[7:2]] <= ram_din;
    end
  end
  assign ram_dout = ram[ram_addr[7:2]];

  // Dropping a request before its ack is illegal.
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (ack[p]) pending[p] = 1'b0;
      else if (req[p]) pending[p] = 1'b1;
      else if (pending[p]) begin
        n_checks++;
        n_fail++;
        $display("FAIL withdraw: port %0d dropped req before ack (observed req=0, required 1)", p);
        pending[p] = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic in_rng(input logic [31:0] a);
    return a < 32'(64 * 4);
  endfunction

  // Applies one completed transaction to the model memory and returns the expected response.
  task automatic model_txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] exp_rd, output logic exp_err);
    int idx;
    idx     = int'(a / 4);
    exp_err = !in_rng(a);
    exp_rd  = 32'h0;
    if (in_rng(a)) begin
      if (w) ref_mem[idx] = d;
      else   exp_rd = ref_mem[idx];
    end
    last_port = p;
  endtask

  task automatic drive(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
  endtask

  task automatic idle(input int p);
    req[p] = 1'b0; we[p] = 1'b0; addr[p] = 32'h0; wdata[p] = 32'h0;
  endtask

  task automatic single_txn(input string tag, input int p, input logic w, input logic [31:0] a,
                            input logic [31:0] d);
    logic [31:0] exp_rd;
    logic        exp_err;
    @(posedge clk); #1;
    drive(p, w, a, d);
    @(negedge clk);
    check({tag, ".ram_we"}, ram_we, w & in_rng(a));
    check({tag, ".ram_addr"}, ram_addr, a);
    if (w) check({tag, ".ram_din"}, ram_din, d);
    model_txn(p, w, a, d, exp_rd, exp_err);
    @(posedge clk); #1;
    check({tag, ".ack"}, ack[p], 1'b1);
    check({tag, ".other_ack"}, ack[1-p], 1'b0);
    check({tag, ".err"}, err[p], exp_err);
    check({tag, ".rdata"}, rdata[p], exp_rd);
    $display("txn %s port=%0d we=%0d addr=%h wdata=%h rdata=%h err=%0d", tag, p, w, a, d, rdata[p], err[p]);
    idle(p);
  endtask

  task automatic pair_txn(input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                          input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          w, l;
    @(posedge clk); #1;
    drive(0, w0, a0, d0);
    drive(1, w1, a1, d1);
    w = 1 - last_port;
    l = 1 - w;
    @(posedge clk); #1;
    model_txn(w, we[w], addr[w], wdata[w], exp_rd, exp_err);
    check("pair.win_ack", ack[w], 1'b1);
    check("pair.lose_ack", ack[l], 1'b0);
    check("pair.win_err", err[w], exp_err);
    check("pair.win_rdata", rdata[w], exp_rd);
    $display("txn pair winner port=%0d addr=%h rdata=%h err=%0d", w, addr[w], rdata[w], err[w]);
    idle(w);
    @(posedge clk); #1;
    model_txn(l, we[l], addr[l], wdata[l], exp_rd, exp_err);
    check("pair.lose_ack2", ack[l], 1'b1);
    check("pair.win_ack2", ack[w], 1'b0);
    check("pair.lose_err", err[l], exp_err);
    check("pair.lose_rdata", rdata[l], exp_rd);
    $display("txn pair loser port=%0d addr=%h rdata=%h err=%0d", l, addr[l], rdata[l], err[l]);
    idle(l);
  endtask

  initial begin
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [31:0] a0, a1;

    rst = 1'b1;
    init_ram = 1'b1;
    idle(0);
    idle(1);
    for (int i = 0; i < 64; i++) ref_mem[i] = i;
    last_port = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.ack", {30'b0, ack}, 32'h0);
    check("reset.err", {30'b0, err}, 32'h0);
    check("reset.rdata0", rdata[0], 32'h0);
    check("reset.rdata1", rdata[1], 32'h0);
    check("reset.ram_we", ram_we, 1'b0);
    @(posedge clk); #1;
    init_ram = 1'b0;
    rst = 1'b0;

    // Contention from reset, then both stream with a fresh read address after every ack.
    @(posedge clk); #1;
    drive(0, 1'b0, 32'h10, 32'h0);
    drive(1, 1'b0, 32'h20, 32'h0);
    for (int c = 0; c < 8; c++) begin
      int w;
      w = 1 - last_port;
      @(posedge clk); #1;
      if (c == 0) check("contend.first_winner", ack[0], 1'b1);
      model_txn(w, we[w], addr[w], 32'h0, exp_rd, exp_err);
      check("stream.ack", ack[w], 1'b1);
      check("stream.other_ack", ack[1-w], 1'b0);
      check("stream.rdata", rdata[w], exp_rd);
      $display("txn stream cycle=%0d port=%0d addr=%h rdata=%h", c, w, addr[w], rdata[w]);
      addr[w] = 32'($urandom_range(0, 63)) * 4;
    end
    idle(0);
    idle(1);

    single_txn("single_rd", 0, 1'b0, 32'h50, 32'h0);
    check("single_rd.const", rdata[0], 32'h14);

    // Port 0 writes in N, port 1 reads the same word in N+1.
    @(posedge clk); #1;
    drive(0, 1'b1, 32'h54, 32'hDEADBEEF);
    @(negedge clk);
    check("raw.ram_we", ram_we, 1'b1);
    model_txn(0, 1'b1, 32'h54, 32'hDEADBEEF, exp_rd, exp_err);
    @(posedge clk); #1;
    check("raw.m0_ack", ack[0], 1'b1);
    idle(0);
    drive(1, 1'b0, 32'h54, 32'h0);
    @(negedge clk);
    check("raw.m1_addr", ram_addr, 32'h54);
    model_txn(1, 1'b0, 32'h54, 32'h0, exp_rd, exp_err);
    @(posedge clk); #1;
    check("raw.m1_ack", ack[1], 1'b1);
    check("raw.m1_rdata", rdata[1], 32'hDEADBEEF);
    $display("txn raw port=1 addr=00000054 rdata=%h", rdata[1]);
    idle(1);

    single_txn("oor_wr", 1, 1'b1, 32'h100, 32'h55);
    check("oor.ram0", ram[0], ref_mem[0]);
    single_txn("oor_readback", 0, 1'b0, 32'h0, 32'h0);
    single_txn("misaligned", 0, 1'b0, 32'h53, 32'h0);
    check("misaligned.const", rdata[0], 32'h14);

    // Reset lands in the middle of a granted write; the held request must complete afterwards.
    @(posedge clk); #1;
    drive(0, 1'b1, 32'h60, 32'hCAFEF00D);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rstmid.ram_we", ram_we, 1'b0);
    check("rstmid.ack", {30'b0, ack}, 32'h0);
    check("rstmid.err", {30'b0, err}, 32'h0);
    check("rstmid.rdata0", rdata[0], 32'h0);
    check("rstmid.rdata1", rdata[1], 32'h0);
    @(posedge clk); #1;
    check("rstmid.word_kept", ram[24], ref_mem[24]);
    rst = 1'b0;
    last_port = 1;
    @(negedge clk);
    check("rstmid.regrant_we", ram_we, 1'b1);
    model_txn(0, 1'b1, 32'h60, 32'hCAFEF00D, exp_rd, exp_err);
    @(posedge clk); #1;
    check("rstmid.ack_after", ack[0], 1'b1);
    check("rstmid.err_after", err[0], 1'b0);
    idle(0);
    @(negedge clk);
    check("rstmid.word_written", ram[24], 32'hCAFEF00D);

    for (int i = 0; i < 30; i++) begin
      a0 = 32'($urandom_range(0, 32'h13F));
      single_txn("rand_single", int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a0, $urandom);
    end
    for (int i = 0; i < 15; i++) begin
      a0 = 32'($urandom_range(0, 32'h13F));
      a1 = (i % 3 == 0) ? a0 : 32'($urandom_range(0, 32'h13F));
      pair_txn(1'($urandom_range(0, 1)), a0, $urandom, 1'($urandom_range(0, 1)), a1, $urandom);
    end
    @(negedge clk);
    for (int i = 0; i < 64; i++) check("final_mem", ram[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/data_ram_arbiter.md
# data_ram_arbiter

Two-port round-robin arbiter that shares the single-port 64-word data RAM between the pipeline MEM stage (port 0) and the debug/loader port (port 1). Each requester holds a level request until a registered acknowledge. The arbiter drives the RAM's address, write data and write enable, and samples its combinational read data. It also range-checks word addresses against the RAM depth. It sits between the MEM stage/debug logic and the data RAM instance.

## Interface
- ADDR_W, 32, byte-address width
- DATA_W, 32, data width
- DEPTH, 64, RAM depth in words; word index = addr >> 2
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- m0_req / m1_req  in  1  access request, level, held until ack
- m0_we / m1_we  in  1  1 = write, 0 = read; stable while req is high
- m0_addr / m1_addr  in  ADDR_W  byte address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_ack / m1_ack  out  1  registered, one-cycle pulse; the transaction is complete
- m0_err / m1_err  out  1  registered, valid with ack; word index >= DEPTH
- m0_rdata / m1_rdata  out  DATA_W  registered read data, valid with ack
- ram_addr  out  ADDR_W  to RAM addr
- ram_din  out  DATA_W  to RAM din
- ram_we  out  1  to RAM we
- ram_dout  in  DATA_W  from RAM dout, combinational read

## Operation
- **Eligibility:** port k is eligible in cycle N when mk_req=1 and mk_ack=0.
  - When mk_ack=1, that cycle is the tail of the finished transaction and the port is masked.
- **Grant:** combinational, at most one port per cycle.
  - One eligible port: that port wins.
  - Both eligible: the port not granted last wins.
  - Register last_grant updates on every grant.
- **Granted cycle:**
  - ram_addr = mk_addr and ram_din = mk_wdata.
  - ram_we = mk_we & in_range & ~rst.
  - in_range = (mk_addr >> 2) < DEPTH, computed on the full ADDR_W.
- **No grant:** ram_addr=0, ram_din=0, ram_we=0.
- **Edge after grant:**
  - mk_ack <= 1.
  - mk_err <= ~in_range.
  - mk_rdata <= (read & in_range) ? ram_dout : 0.
  - mk_rdata <= 0 on writes.
- **Non-granted port:** ack and err are 0. rdata holds its last value.
- **Alignment:** misaligned addresses (addr[1:0]≠0) are not errors; the low bits are dropped, matching RAM indexing.
- **Out-of-range:** the transaction is still acknowledged, with err=1 and no RAM write.

## Timing
- **Latency:** request in cycle N with no contention → ack in cycle N+1.
  - A contended loser is granted in N+1 and acked in N+2.
- **Throughput:** one access per port per 2 cycles.
  - With both ports streaming, the RAM is busy every cycle, alternating 0,1,0,1.
- **Back-to-back:** the requester may keep req high through its ack cycle to issue the next transaction. That transaction becomes eligible in the cycle after the ack.
- **Read-after-write:** a write by port 0 in N followed by a read of the same address by port 1 in N+1 returns the new data. The RAM writes at the N edge and reads combinationally.
- **Reset values:** all mk_ack=0, mk_err=0, mk_rdata=0; last_grant=1, so port 0 wins the first tie.
- **Reset mid-operation:** rst asynchronously clears the registers. ram_we is forced 0 while rst=1, so no partial write occurs. A pending request is re-arbitrated after rst deasserts.
- **Request withdrawal:** dropping req before ack is illegal. The bench flags it; the RTL behaviour is don't-care.

## Structure
- Shared package: ADDR_W, DATA_W, DEPTH defaults, and the port-index constants P_MEM=0, P_DBG=1.
- One natural sub-module: `rr_arb2`, a 2-input round-robin grant with the last_grant register, reusable elsewhere.
- Top level holds the muxing, range check and response registers.

## Test plan
- **Single read:** m0 reads addr 0x50 with RAM word 20 = 0x14 → m0_ack at N+1, m0_rdata=0x00000014, m0_err=0.
- **Write then read, cross-port:** m0 writes 0xDEADBEEF to 0x54 in N; m1 reads 0x54 from N+1 → m1_rdata=0xDEADBEEF at N+2.
- **Contention:** both request in N after reset → m0 acked at N+1, m1 acked at N+2. Both then hold req → grants alternate every cycle, with no port starved more than 1 cycle.
- **Out-of-range:** m1 writes 0x55 to addr 0x100 (index 64) → ram_we stays 0, m1_ack=1 and m1_err=1 at N+1, RAM contents unchanged. Readback of index 0 is unaffected.
- **Misaligned:** m0 reads 0x53 → returns word 20, err=0.
- **Reset mid-write:** assert rst during m0's granted write cycle → ram_we=0, the target word keeps its old value, and all ack/err/rdata=0. After release, the held request is acked one cycle after its grant.
